// File: rtl/seven_seg_scanner_param.sv
// Multiplexed N-digit seven-segment scanner with a built-in slot prescaler,
// per-digit participation mask, anti-ghosting blank interval and hex decode.
module seven_seg_scanner_param #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 16,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [NUM_DIGITS-1:0]   digit_mask_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [NUM_DIGITS-1:0]   anode_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [IDX_W-1:0]        digit_index_o,
    output logic                    frame_start_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]      count_q, count_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [IDX_W-1:0]      digit_index_q;
    logic                  frame_start_q, frame_start_d;

    logic                  tick;
    logic                  in_blank;
    logic                  mask_any;
    logic [IDX_W-1:0]      next_idx;
    logic [6:0]            seg_dec [NUM_DIGITS];

    assign tick     = (count_q == CNT_W'(SCAN_DIV - 1));
    assign mask_any = |digit_mask_i;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (count_q < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
            assign seg_dec[gi] = hex7(digits_i[4*gi +: 4]);
        end
    endgenerate

    // Next participating digit above idx, else wrap to the lowest set bit;
    // an empty mask leaves idx where it is.
    always_comb begin
        logic [IDX_W-1:0] above;
        logic [IDX_W-1:0] lowest;
        logic             found;
        above  = idx_q;
        lowest = idx_q;
        found  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (digit_mask_i[i]) begin
                lowest = IDX_W'(i);
                if (i > int'(idx_q)) begin
                    above = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end
        next_idx = idx_q;
        if (found) begin
            next_idx = above;
        end else if (mask_any) begin
            next_idx = lowest;
        end
    end

    always_comb begin
        count_d = count_q;
        idx_d   = idx_q;
        if (enable_i) begin
            if (tick) begin
                count_d = '0;
                idx_d   = next_idx;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        anode_d       = '1;
        seg_d         = 7'h7F;
        dp_d          = 1'b1;
        frame_start_d = enable_i && tick && mask_any && (next_idx <= idx_q);
        if (enable_i && !in_blank && digit_mask_i[idx_q]) begin
            anode_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d   = seg_dec[idx_q];
            dp_d    = ~dp_i[idx_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q       <= '0;
            idx_q         <= '0;
            anode_q       <= '1;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            digit_index_q <= '0;
            frame_start_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            idx_q         <= idx_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            digit_index_q <= idx_q;
            frame_start_q <= frame_start_d;
        end
    end

    assign anode_o       = anode_q;
    assign seg_o         = seg_q;
    assign dp_o          = dp_q;
    assign digit_index_o = digit_index_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner_param.sv
// Directed bench for seven_seg_scanner_param (4 digits, 8-cycle slots, 2 blank
// cycles) plus a 2-digit instance with no blank interval.
module tb_seven_seg_scanner_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  mask;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  didx;
    logic        fs;

    logic [1:0]  anode2;
    logic [6:0]  seg2;
    logic        dp2;
    logic        didx2;
    logic        fs2;

    int checks   = 0;
    int failures = 0;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_scanner_param #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .digit_mask_i(mask),
        .digits_i(digits), .dp_i(dp_in), .anode_o(anode), .seg_o(seg), .dp_o(dp),
        .digit_index_o(didx), .frame_start_o(fs)
    );

    seven_seg_scanner_param #(.NUM_DIGITS(2), .SCAN_DIV(4), .BLANK_CYCLES(0)) dut_nb (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .digit_mask_i(mask[1:0]),
        .digits_i(digits[7:0]), .dp_i(dp_in[1:0]), .anode_o(anode2), .seg_o(seg2), .dp_o(dp2),
        .digit_index_o(didx2), .frame_start_o(fs2)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        mask = 4'hF; digits = 16'h3210; dp_in = 4'h0; enable = 1'b1;
        do_reset();
        checks++; if (anode !== 4'hF) begin failures++; $display("FAIL reset_anode got=%b exp=1111", anode); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp); end
        checks++; if (didx !== 2'd0) begin failures++; $display("FAIL reset_didx got=%0d exp=0", didx); end
        checks++; if (fs !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", fs); end
        for (int e = 1; e <= 12; e++) begin
            step();
            exp_an  = (e <= 2 || e == 9 || e == 10) ? 4'hF : (e <= 8 ? 4'hE : 4'hD);
            exp_seg = (e >= 3 && e <= 8) ? 7'h40 : (e >= 11 ? 7'h79 : 7'h7F);
            checks++; if (anode !== exp_an) begin failures++; $display("FAIL release_anode e=%0d got=%b exp=%b", e, anode, exp_an); end
            checks++; if (seg !== exp_seg) begin failures++; $display("FAIL release_seg e=%0d got=%h exp=%h", e, seg, exp_seg); end
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_full_frame;
        logic [3:0] exp_an;
        logic       exp_fs;
        int c, s;
        mask = 4'hF; digits = 16'h3210; enable = 1'b1;
        do_reset();
        for (int e = 1; e <= 70; e++) begin
            step();
            c = (e - 1) % 8;
            s = ((e - 1) / 8) % 4;
            exp_an = (c >= 2) ? ~(4'b0001 << s) : 4'hF;
            exp_fs = (e % 32 == 0);
            checks++; if (anode !== exp_an) begin failures++; $display("FAIL frame_anode e=%0d got=%b exp=%b", e, anode, exp_an); end
            checks++; if (fs !== exp_fs) begin failures++; $display("FAIL frame_fs e=%0d got=%b exp=%b", e, fs, exp_fs); end
            if (c >= 2) begin
                checks++; if (didx !== 2'(s)) begin failures++; $display("FAIL frame_didx e=%0d got=%0d exp=%0d", e, didx, s); end
            end
        end
        $display("test_full_frame done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_mask_sparse;
        logic [3:0] exp_an;
        logic       exp_fs;
        int c, s;
        mask = 4'b0101; digits = 16'h3210; enable = 1'b1;
        do_reset();
        for (int e = 1; e <= 48; e++) begin
            step();
            c = (e - 1) % 8;
            s = (((e - 1) / 8) % 2 == 1) ? 2 : 0;
            exp_an = (c >= 2) ? ~(4'b0001 << s) : 4'hF;
            exp_fs = (e % 16 == 0);
            checks++; if (anode !== exp_an) begin failures++; $display("FAIL sparse_anode e=%0d got=%b exp=%b", e, anode, exp_an); end
            checks++; if (fs !== exp_fs) begin failures++; $display("FAIL sparse_fs e=%0d got=%b exp=%b", e, fs, exp_fs); end
        end
        $display("test_mask_sparse done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_mask_zero;
        mask = 4'h0; digits = 16'h3210; enable = 1'b1;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            step();
            checks++; if (anode !== 4'hF) begin failures++; $display("FAIL zero_anode e=%0d got=%b exp=1111", e, anode); end
            checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL zero_seg e=%0d got=%h exp=7f", e, seg); end
            checks++; if (didx !== 2'd0) begin failures++; $display("FAIL zero_didx e=%0d got=%0d exp=0", e, didx); end
            checks++; if (fs !== 1'b0) begin failures++; $display("FAIL zero_fs e=%0d got=%b exp=0", e, fs); end
        end
        $display("test_mask_zero done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_enable_pause;
        int shows;
        mask = 4'hF; digits = 16'h3210; dp_in = 4'h0; enable = 1'b1;
        do_reset();
        for (int e = 1; e <= 20; e++) step();
        checks++; if (anode !== 4'b1011 || seg !== 7'h24) begin failures++; $display("FAIL pause_pre got=%b/%h exp=1011/24", anode, seg); end
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (anode !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin failures++; $display("FAIL pause_blank k=%0d got=%b/%h/%b exp=1111/7f/1", k, anode, seg, dp); end
            checks++; if (fs !== 1'b0) begin failures++; $display("FAIL pause_fs k=%0d got=%b exp=0", k, fs); end
        end
        enable = 1'b1;
        shows = 2;
        for (int e = 26; e <= 32; e++) begin
            step();
            if (anode == 4'b1011) shows++;
            if (e == 30 || e == 31) begin
                checks++; if (anode !== 4'hF) begin failures++; $display("FAIL pause_gap e=%0d got=%b exp=1111", e, anode); end
            end
        end
        checks++; if (shows !== 6) begin failures++; $display("FAIL pause_show_count got=%0d exp=6", shows); end
        checks++; if (anode !== 4'b0111 || seg !== 7'h30) begin failures++; $display("FAIL pause_next got=%b/%h exp=0111/30", anode, seg); end
        $display("test_enable_pause done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid_slot;
        mask = 4'hF; digits = 16'hFEDC; dp_in = 4'b1000; enable = 1'b1;
        do_reset();
        for (int e = 1; e <= 28; e++) step();
        checks++; if (anode !== 4'b0111 || seg !== 7'h0E || dp !== 1'b0) begin failures++; $display("FAIL mid_pre got=%b/%h/%b exp=0111/0e/0", anode, seg, dp); end
        rst_n = 1'b0;
        step();
        checks++; if (anode !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin failures++; $display("FAIL mid_rst_out got=%b/%h/%b exp=1111/7f/1", anode, seg, dp); end
        checks++; if (didx !== 2'd0 || fs !== 1'b0) begin failures++; $display("FAIL mid_rst_idx got=%0d/%b exp=0/0", didx, fs); end
        rst_n = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            step();
            checks++; if (anode !== 4'hF) begin failures++; $display("FAIL mid_blank e=%0d got=%b exp=1111", e, anode); end
        end
        step();
        checks++; if (anode !== 4'hE || seg !== 7'h46 || dp !== 1'b1) begin failures++; $display("FAIL mid_restart got=%b/%h/%b exp=1110/46/1", anode, seg, dp); end
        // live data and mask changes land on the very next edge
        digits = 16'hFED5;
        step();
        checks++; if (anode !== 4'hE || seg !== 7'h12) begin failures++; $display("FAIL live_digit got=%b/%h exp=1110/12", anode, seg); end
        mask = 4'hE;
        step();
        checks++; if (anode !== 4'hF || seg !== 7'h7F) begin failures++; $display("FAIL live_mask got=%b/%h exp=1111/7f", anode, seg); end
        $display("test_reset_mid_slot done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_hex_table;
        int nib;
        int c;
        mask = 4'h1; digits = 16'h0; dp_in = 4'h0; enable = 1'b1;
        do_reset();
        nib = 0;
        for (int e = 1; e <= 40 && nib < 16; e++) begin
            digits = {12'h000, 4'(nib)};
            step();
            c = (e - 1) % 8;
            checks++; if (fs !== (e % 8 == 0)) begin failures++; $display("FAIL single_fs e=%0d got=%b exp=%b", e, fs, (e % 8 == 0)); end
            if (c >= 2) begin
                checks++; if (anode !== 4'hE || seg !== tbl[nib]) begin failures++; $display("FAIL hex_%0h got=%b/%h exp=1110/%h", nib, anode, seg, tbl[nib]); end
                nib++;
            end
        end
        $display("test_hex_table done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_no_blank;
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
        int s;
        mask = 4'hF; digits = 16'h3210; enable = 1'b1;
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            step();
            s = ((e - 1) / 4) % 2;
            exp_an  = ~(2'b01 << s);
            exp_seg = (s == 1) ? 7'h79 : 7'h40;
            checks++; if (anode2 !== exp_an || seg2 !== exp_seg) begin failures++; $display("FAIL noblank e=%0d got=%b/%h exp=%b/%h", e, anode2, seg2, exp_an, exp_seg); end
            checks++; if (fs2 !== (e % 8 == 0)) begin failures++; $display("FAIL noblank_fs e=%0d got=%b exp=%b", e, fs2, (e % 8 == 0)); end
        end
        $display("test_no_blank done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; mask = 4'h0; digits = 16'h0; dp_in = 4'h0;
        test_reset();
        test_full_frame();
        test_mask_sparse();
        test_mask_zero();
        test_enable_pause();
        test_reset_mid_slot();
        test_hex_table();
        test_no_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
